// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer and miss-fill arbiter for the 5-stage pipeline. Optional stall counter: PIPE_PERF_CNT_EN.
// Latency: stall/flush controls are combinational; fill_done is a registered pulse one cycle after the last word.
// Backpressure: a D-side stall freezes PC..EX/MEM and bubbles MEM/WB; an I-fill or hazard holds the front end.
module pipeline_ctrl #(
    parameter int WORDS = 8,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          I_miss,
    input  logic          D_miss,
    input  logic          mem_data_valid,
    input  logic          EX_MemRead,
    input  logic [3:0]    EX_Rd,
    input  logic [3:0]    ID_Rs,
    input  logic [3:0]    ID_Rt,
    input  logic          ID_uses_rs,
    input  logic          ID_uses_rt,
    input  logic          ID_branch_taken,
    output logic          PC_wen,
    output logic          IF_ID_wen,
    output logic          ID_EX_wen,
    output logic          EX_MEM_wen,
    output logic          MEM_WB_wen,
    output logic          IF_ID_flush,
    output logic          ID_EX_flush,
    output logic          MEM_WB_flush,
    output logic          mem_req,
    output logic          mem_sel,
    output logic          fill_we,
    output logic [CW-1:0] fill_word,
    output logic          fill_done,
    output logic [15:0]   stall_cycles
);

    typedef enum logic [1:0] {IDLE, DFILL, IFILL} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          filling;
    logic          last_word;
    logic          dstall;
    logic          ifetch;
    logic          loaduse;
    logic          hold_id;

    assign filling   = (state != IDLE);
    assign last_word = filling && mem_data_valid && (cnt == CW'(WORDS - 1));
    assign fill_word = cnt;

    assign dstall  = D_miss || (state == DFILL);
    assign ifetch  = !dstall && (I_miss || (state == IFILL));
    assign loaduse = EX_MemRead && (EX_Rd != 4'd0) &&
                     ((ID_uses_rs && (EX_Rd == ID_Rs)) || (ID_uses_rt && (EX_Rd == ID_Rt)));
    assign hold_id = !dstall && (loaduse || (ID_branch_taken && ifetch));

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Arbitration: D-side wins from IDLE; a pending D miss chains straight after an I fill
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (D_miss)      state_nxt = DFILL;
                else if (I_miss) state_nxt = IFILL;
            end
            IFILL: if (last_word) state_nxt = D_miss ? DFILL : IDLE;
            DFILL: if (last_word) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Word counter and completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            fill_done <= 1'b0;
        end else begin
            fill_done <= last_word;
            if (last_word)                   cnt <= '0;
            else if (filling && mem_data_valid) cnt <= cnt + 1'b1;
        end
    end

    // Memory port and stage controls, highest-priority hazard first
    always_comb begin
        mem_req      = filling;
        mem_sel      = (state == DFILL);
        fill_we      = filling && mem_data_valid;
        PC_wen       = 1'b1;
        IF_ID_wen    = 1'b1;
        ID_EX_wen    = 1'b1;
        EX_MEM_wen   = 1'b1;
        MEM_WB_wen   = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        MEM_WB_flush = 1'b0;
        if (dstall) begin
            PC_wen       = 1'b0;
            IF_ID_wen    = 1'b0;
            ID_EX_wen    = 1'b0;
            EX_MEM_wen   = 1'b0;
            MEM_WB_flush = 1'b1;
        end else begin
            if (ifetch) begin
                PC_wen      = 1'b0;
                IF_ID_flush = 1'b1;
            end
            if (hold_id) begin
                PC_wen      = 1'b0;
                IF_ID_wen   = 1'b0;
                IF_ID_flush = 1'b0;
                ID_EX_flush = 1'b1;
            end else if (ID_branch_taken && !ifetch) begin
                IF_ID_flush = 1'b1;
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    // Saturating count of cycles in which the PC is frozen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               stall_cycles <= 16'd0;
        else if (!PC_wen && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
    end
`else
    assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench: driver pushes expected outputs from a behavioural model, monitor compares at negedge.
// Latency: expectations are for the same cycle's combinational outputs and registered state.
// Backpressure: none; one expectation per clock cycle.
module tb_pipeline_ctrl;

    localparam int WORDS = 8;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          I_miss, D_miss, mem_data_valid;
    logic          EX_MemRead;
    logic [3:0]    EX_Rd, ID_Rs, ID_Rt;
    logic          ID_uses_rs, ID_uses_rt, ID_branch_taken;
    logic          PC_wen, IF_ID_wen, ID_EX_wen, EX_MEM_wen, MEM_WB_wen;
    logic          IF_ID_flush, ID_EX_flush, MEM_WB_flush;
    logic          mem_req, mem_sel, fill_we, fill_done;
    logic [CW-1:0] fill_word;
    logic [15:0]   stall_cycles;

    pipeline_ctrl #(.WORDS(WORDS), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .I_miss(I_miss), .D_miss(D_miss),
        .mem_data_valid(mem_data_valid), .EX_MemRead(EX_MemRead), .EX_Rd(EX_Rd),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
        .ID_branch_taken(ID_branch_taken), .PC_wen(PC_wen), .IF_ID_wen(IF_ID_wen),
        .ID_EX_wen(ID_EX_wen), .EX_MEM_wen(EX_MEM_wen), .MEM_WB_wen(MEM_WB_wen),
        .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush), .MEM_WB_flush(MEM_WB_flush),
        .mem_req(mem_req), .mem_sel(mem_sel), .fill_we(fill_we), .fill_word(fill_word),
        .fill_done(fill_done), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        pc, ifid_w, idex_w, exmem_w, memwb_w;
        logic        ifid_f, idex_f, memwb_f;
        logic        req, sel, we;
        logic [2:0]  word;
        logic        done;
        logic [15:0] sc;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   failed = 0;

    // Behavioural model: who owns memory, how many words arrived, pulse and stall tally
    int   owner;        // 0 none, 1 I-cache, 2 D-cache
    int   words;
    bit   done;
    int   scnt;
    bit   prev_pc;
    bit   i_pend, d_pend;

    task automatic model_advance();
        int completed;
        bit done_n;
        completed = 0;
        done_n    = 0;
        if (!rst_n) begin
            owner = 0; words = 0; done = 0; scnt = 0; prev_pc = 1;
            return;
        end
`ifdef PIPE_PERF_CNT_EN
        if (!prev_pc && scnt < 65535) scnt++;
`endif
        if (owner == 0) begin
            if (D_miss)      owner = 2;
            else if (I_miss) owner = 1;
        end else if (mem_data_valid) begin
            words++;
            if (words == WORDS) begin
                done_n    = 1;
                completed = owner;
                words     = 0;
                owner     = (owner == 1 && D_miss) ? 2 : 0;
            end
        end
        done = done_n;
        // a cache drops its miss once the block is written
        if (done && completed == 1) i_pend = 0;
        if (done && completed == 2) d_pend = 0;
    endtask

    function automatic exp_t model_outputs();
        exp_t e;
        bit dst, ifet, lu, hold;
        dst  = D_miss || owner == 2;
        ifet = !dst && (I_miss || owner == 1);
        lu   = EX_MemRead && EX_Rd != 0 &&
               ((ID_uses_rs && EX_Rd == ID_Rs) || (ID_uses_rt && EX_Rd == ID_Rt));
        hold = !dst && (lu || (ID_branch_taken && ifet));
        e = '0;
        e.req  = (owner != 0);
        e.sel  = (owner == 2);
        e.we   = (owner != 0) && mem_data_valid;
        e.word = 3'(words);
        e.done = done;
        e.sc   = 16'(scnt);
        if (dst) begin
            {e.pc, e.ifid_w, e.idex_w, e.exmem_w, e.memwb_w} = 5'b00001;
            {e.ifid_f, e.idex_f, e.memwb_f} = 3'b001;
        end else if (hold) begin
            {e.pc, e.ifid_w, e.idex_w, e.exmem_w, e.memwb_w} = 5'b00111;
            {e.ifid_f, e.idex_f, e.memwb_f} = 3'b010;
        end else if (ifet) begin
            {e.pc, e.ifid_w, e.idex_w, e.exmem_w, e.memwb_w} = 5'b01111;
            {e.ifid_f, e.idex_f, e.memwb_f} = 3'b100;
        end else begin
            {e.pc, e.ifid_w, e.idex_w, e.exmem_w, e.memwb_w} = 5'b11111;
            {e.ifid_f, e.idex_f, e.memwb_f} = {ID_branch_taken, 2'b00};
        end
        return e;
    endfunction

    // One clock: retire last cycle into the model, apply new inputs, queue expectation
    task automatic step(input bit mdv, input bit mr, input logic [3:0] rd, input logic [3:0] rs,
                        input logic [3:0] rt, input bit urs, input bit urt, input bit br);
        exp_t e;
        @(posedge clk);
        #1;
        model_advance();
        I_miss = i_pend; D_miss = d_pend; mem_data_valid = mdv;
        EX_MemRead = mr; EX_Rd = rd; ID_Rs = rs; ID_Rt = rt;
        ID_uses_rs = urs; ID_uses_rt = urt; ID_branch_taken = br;
        e = model_outputs();
        prev_pc = e.pc;
        exp_q.push_back(e);
    endtask

    task automatic idle_step(input bit mdv);
        step(mdv, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0);
    endtask

    task automatic set_reset(input logic v);
        @(posedge clk);
        #1;
        rst_n = v;
        model_advance();
    endtask

    // Monitor: compare the DUT against the oldest expectation each cycle
    initial begin
        exp_t a, e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {PC_wen, IF_ID_wen, ID_EX_wen, EX_MEM_wen, MEM_WB_wen,
                     IF_ID_flush, ID_EX_flush, MEM_WB_flush, mem_req, mem_sel, fill_we,
                     fill_word, fill_done, stall_cycles};
                tests++;
                if (a !== e) begin
                    failed++;
                    $display("FAIL outputs @%0t: actual=%h required=%h", $time, a, e);
                end
            end
        end
    end

    initial begin
        rst_n = 0; i_pend = 0; d_pend = 0;
        I_miss = 0; D_miss = 0; mem_data_valid = 0; EX_MemRead = 0;
        EX_Rd = 0; ID_Rs = 0; ID_Rt = 0; ID_uses_rs = 0; ID_uses_rt = 0; ID_branch_taken = 0;
        owner = 0; words = 0; done = 0; scnt = 0; prev_pc = 1;
        repeat (2) idle_step(0);
        set_reset(1);
        repeat (3) idle_step(1);

        // D fill interrupted by reset after 3 words, restarted by the held miss
        d_pend = 1;
        idle_step(0);
        repeat (3) idle_step(1);
        @(posedge clk); #1; rst_n = 0; model_advance();
        repeat (2) idle_step(0);
        set_reset(1);
        repeat (10) idle_step(1);

        // simultaneous misses: D first, then I
        i_pend = 1; d_pend = 1;
        repeat (22) idle_step(($urandom_range(0, 3) != 0));
        repeat (4) idle_step(0);

        // load-use on Rt, then EX_Rd=0 (no stall), then Rs match
        step(0, 1, 4'd5, 4'd1, 4'd5, 0, 1, 0);
        step(0, 0, 4'd5, 4'd1, 4'd5, 0, 1, 0);
        step(0, 1, 4'd0, 4'd0, 4'd0, 1, 1, 0);
        step(0, 1, 4'd7, 4'd7, 4'd2, 1, 0, 1);
        step(0, 1, 4'd7, 4'd7, 4'd2, 0, 1, 0);
        // taken branch, no hazards
        step(0, 0, 4'd3, 4'd3, 4'd3, 1, 1, 1);

        // branch held during an I fill, redirects once the fill is over
        i_pend = 1;
        for (int k = 0; k < 14; k++) step((k % 3) != 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 1);
        repeat (4) step(1, 0, 4'd0, 4'd0, 4'd0, 0, 0, 1);

        // a D miss arriving during an I fill chains directly into the D fill
        i_pend = 1;
        repeat (3) idle_step(1);
        d_pend = 1;
        repeat (20) idle_step(1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (!i_pend && $urandom_range(0, 15) == 0) i_pend = 1;
            if (!d_pend && $urandom_range(0, 19) == 0) d_pend = 1;
            step($urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom_range(0, 3)),
                 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) == 0);
        end

`ifdef PIPE_PERF_CNT_EN
        // exactly ten stall cycles, then drive the counter into saturation
        repeat (2) idle_step(0);
        @(posedge clk); #1; rst_n = 0; i_pend = 0; d_pend = 0; I_miss = 0; D_miss = 0; model_advance();
        set_reset(1);
        i_pend = 1;
        repeat (10) idle_step(0);
        i_pend = 0; I_miss = 0;
        @(posedge clk); #1; rst_n = 0; model_advance();
        set_reset(1);
        d_pend = 1;
        repeat (65540) idle_step(0);
        repeat (12) idle_step(1);
        repeat (3) idle_step(0);
`endif

        @(negedge clk);
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
